// File: rtl/rf_trace_pkg.sv
// Shared types and constants for the register-file write tracer.
package rf_trace_pkg;

    localparam int REG_AW      = 5;
    localparam int RSTATUS_REG = 30;

    typedef enum logic [1:0] {
        ARMED,
        POST,
        FROZEN
    } trace_state_t;

    // r0 is hardwired, so writes to it never reach the shadow or the trace.
    function automatic logic is_reg_write(input logic we, input logic [REG_AW-1:0] addr);
        return we && (addr != '0);
    endfunction

endpackage

// File: rtl/rf_write_tracer_fifo.sv
// Synchronous trace FIFO with flush; head is visible the cycle after the push.
module trace_fifo #(
    parameter int  DEPTH   = 16,
    parameter type entry_t = logic [31:0]
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  entry_t                 din,
    output entry_t                 dout,
    output logic                   valid,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    entry_t        mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign valid   = (wr_ptr != rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign do_pop  = pop && valid && !flush;
    // A pop in the same cycle frees the slot the push lands in.
    assign do_push = push && (!full || do_pop) && !flush;
    assign dout    = valid ? mem[rd_ptr[AW-1:0]] : '0;

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/rf_write_tracer.sv
// Passive regfile write tracer: shadow registers, stamped trace FIFO and
// a post-trigger capture window that freezes after a write to rstatus.
module rf_write_tracer
    import rf_trace_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int STAMP_W   = 16,
    parameter int TRIG_REG  = RSTATUS_REG,
    parameter int POST_TRIG = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   rf_we,
    input  logic [4:0]             rf_waddr,
    input  logic [31:0]            rf_wdata,
    input  logic [4:0]             dbg_raddr,
    output logic [31:0]            dbg_rdata,
    input  logic                   rearm,
    output logic                   trc_valid,
    input  logic                   trc_ready,
    output logic [STAMP_W-1:0]     trc_stamp,
    output logic [4:0]             trc_addr,
    output logic [31:0]            trc_data,
    output logic [$clog2(DEPTH):0] trc_count,
    output logic                   overflow,
    output logic                   frozen
);

    localparam int CNT_W = $clog2(POST_TRIG + 1) + 1;

    typedef struct packed {
        logic [STAMP_W-1:0] stamp;
        logic [4:0]         addr;
        logic [31:0]        data;
    } entry_t;

    logic [STAMP_W-1:0] stamp;
    logic [31:0]        shadow [32];
    trace_state_t       state;
    trace_state_t       next_state;
    logic [CNT_W-1:0]   post_cnt;
    logic [CNT_W-1:0]   next_cnt;
    logic               reg_write;
    logic               qualify;
    logic               pop;
    logic               full;
    entry_t             new_entry;
    entry_t             head;

    assign reg_write = is_reg_write(rf_we, rf_waddr);
    assign qualify   = reg_write && (state != FROZEN);
    assign pop       = trc_valid && trc_ready;
    assign frozen    = (state == FROZEN);
    assign dbg_rdata = (dbg_raddr == '0) ? '0 : shadow[dbg_raddr];

    assign new_entry = '{stamp: stamp, addr: rf_waddr, data: rf_wdata};
    assign trc_stamp = head.stamp;
    assign trc_addr  = head.addr;
    assign trc_data  = head.data;

    always_ff @(posedge clock) begin
        if (!reset) stamp <= '0;
        else        stamp <= stamp + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int unsigned i = 0; i < 32; i++) shadow[i] <= '0;
        end else if (reg_write) begin
            shadow[rf_waddr] <= rf_wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset)                        overflow <= 1'b0;
        else if (rearm)                    overflow <= 1'b0;
        else if (qualify && full && !pop)  overflow <= 1'b1;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= ARMED;
            post_cnt <= '0;
        end else begin
            state    <= next_state;
            post_cnt <= next_cnt;
        end
    end

    // Dropped writes in POST still consume the window, so count on qualify, not on push.
    always_comb begin
        next_state = state;
        next_cnt   = post_cnt;
        if (rearm) begin
            next_state = ARMED;
        end else begin
            unique case (state)
                ARMED: begin
                    if (qualify && (rf_waddr == 5'(TRIG_REG))) begin
                        next_cnt   = CNT_W'(POST_TRIG);
                        next_state = (POST_TRIG == 0) ? FROZEN : POST;
                    end
                end
                POST: begin
                    if (qualify) begin
                        next_cnt = post_cnt - 1'b1;
                        if (post_cnt == CNT_W'(1)) next_state = FROZEN;
                    end
                end
                FROZEN: ;
                default: next_state = ARMED;
            endcase
        end
    end

    trace_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .flush (rearm),
        .push  (qualify),
        .pop   (trc_ready),
        .din   (new_entry),
        .dout  (head),
        .valid (trc_valid),
        .full  (full),
        .count (trc_count)
    );

endmodule

// File: tb/tb_rf_write_tracer.sv
// Directed bench for rf_write_tracer: a default instance plus a 4-bit-stamp,
// freeze-on-trigger instance driven with identical stimulus.
module tb_rf_write_tracer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        rf_we = 1'b0;
    logic [4:0]  rf_waddr = '0;
    logic [31:0] rf_wdata = '0;
    logic [4:0]  dbg_raddr = '0;
    logic        rearm = 1'b0;
    logic        trc_ready = 1'b0;

    logic [31:0] a_rdata, b_rdata;
    logic        a_valid, b_valid;
    logic [15:0] a_stamp;
    logic [3:0]  b_stamp;
    logic [4:0]  a_addr, b_addr;
    logic [31:0] a_data, b_data;
    logic [4:0]  a_count, b_count;
    logic        a_ovf, b_ovf;
    logic        a_frozen, b_frozen;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    rf_write_tracer #(.DEPTH(16), .STAMP_W(16), .TRIG_REG(30), .POST_TRIG(4)) dut_a (
        .clock(clock), .reset(reset), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .dbg_raddr(dbg_raddr), .dbg_rdata(a_rdata), .rearm(rearm), .trc_valid(a_valid),
        .trc_ready(trc_ready), .trc_stamp(a_stamp), .trc_addr(a_addr), .trc_data(a_data),
        .trc_count(a_count), .overflow(a_ovf), .frozen(a_frozen)
    );

    rf_write_tracer #(.DEPTH(16), .STAMP_W(4), .TRIG_REG(30), .POST_TRIG(0)) dut_b (
        .clock(clock), .reset(reset), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .dbg_raddr(dbg_raddr), .dbg_rdata(b_rdata), .rearm(rearm), .trc_valid(b_valid),
        .trc_ready(trc_ready), .trc_stamp(b_stamp), .trc_addr(b_addr), .trc_data(b_data),
        .trc_count(b_count), .overflow(b_ovf), .frozen(b_frozen)
    );

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [4:0]  raddr;
        logic        ready;
        logic        chk_head;
        logic        exp_valid;
        logic [4:0]  exp_count;
        logic [15:0] exp_stamp;
        logic [4:0]  exp_addr;
        logic [31:0] exp_data;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic we, input logic [4:0] addr, input logic [31:0] data,
                         input logic [4:0] raddr, input logic ready, input logic rearm_i);
        rf_we     = we;
        rf_waddr  = addr;
        rf_wdata  = data;
        dbg_raddr = raddr;
        trc_ready = ready;
        rearm     = rearm_i;
    endtask

    task automatic write_tick(input logic [4:0] addr, input logic [31:0] data, input logic ready);
        drive(1'b1, addr, data, 5'd0, ready, 1'b0);
        tick();
        drive(1'b0, 5'd0, 32'd0, 5'd0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //               we waddr  wdata   raddr  rdy chk val cnt stamp  addr   data    rdata
        vecs[0] = '{1'b1, 5'd3, 32'h11, 5'd3, 1'b1, 1'b1, 1'b1, 5'd1, 16'd7, 5'd3, 32'h11, 32'h11};
        vecs[1] = '{1'b1, 5'd0, 32'hFF, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 16'd0, 5'd0, 32'h0,  32'h0};
        vecs[2] = '{1'b1, 5'd4, 32'h22, 5'd3, 1'b1, 1'b1, 1'b1, 5'd1, 16'd9, 5'd4, 32'h22, 32'h11};
        vecs[3] = '{1'b0, 5'd0, 32'h0,  5'd4, 1'b1, 1'b0, 1'b0, 5'd0, 16'd0, 5'd0, 32'h0,  32'h22};
        vecs[4] = '{1'b0, 5'd0, 32'h0,  5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 16'd0, 5'd0, 32'h0,  32'h0};

        // T1: reset held with writes requested
        drive(1'b1, 5'd5, 32'hAB, 5'd5, 1'b0, 1'b0);
        repeat (3) tick();
        chk("t1_valid", a_valid, 0);
        chk("t1_count", a_count, 0);
        chk("t1_ovf", a_ovf, 0);
        chk("t1_frozen", a_frozen, 0);
        chk("t1_head", {a_stamp, a_addr, a_data}, 0);
        chk("t1_r5", a_rdata, 0);
        chk("t1_b_state", {b_valid, b_count, b_ovf, b_frozen, b_stamp}, 0);
        drive(1'b0, 5'd0, 32'd0, 5'd0, 1'b0, 1'b0);
        reset = 1'b1;

        // T2: cycles 0..6 idle, table starts in cycle 7
        repeat (7) tick();
        for (int i = 0; i < 5; i++) begin
            drive(vecs[i].we, vecs[i].waddr, vecs[i].wdata, vecs[i].raddr, vecs[i].ready, 1'b0);
            tick();
            chk($sformatf("t2_valid[%0d]", i), a_valid, vecs[i].exp_valid);
            chk($sformatf("t2_count[%0d]", i), a_count, vecs[i].exp_count);
            chk($sformatf("t2_rdata[%0d]", i), a_rdata, vecs[i].exp_rdata);
            if (vecs[i].chk_head) begin
                chk($sformatf("t2_stamp[%0d]", i), a_stamp, vecs[i].exp_stamp);
                chk($sformatf("t2_addr[%0d]", i), a_addr, vecs[i].exp_addr);
                chk($sformatf("t2_data[%0d]", i), a_data, vecs[i].exp_data);
            end
        end

        // No bypass: cycle 12 write to r3 reads the old value until the edge
        drive(1'b1, 5'd3, 32'h33, 5'd3, 1'b0, 1'b0);
        #1;
        chk("nobypass_old", a_rdata, 32'h11);
        tick();
        chk("nobypass_new", a_rdata, 32'h33);
        chk("nobypass_stamp", a_stamp, 16'd12);
        chk("nobypass_count", a_count, 1);
        drive(1'b0, 5'd0, 32'd0, 5'd0, 1'b1, 1'b0);
        tick();
        chk("drain_count", a_count, 0);

        // T3: overflow with 17 writes and no consumer
        for (int i = 0; i < 17; i++) begin
            write_tick(5'(1 + (i % 16)), 32'h100 + 32'(i), 1'b0);
            chk($sformatf("t3_hold_addr[%0d]", i), a_addr, 5'd1);
            chk($sformatf("t3_hold_data[%0d]", i), a_data, 32'h100);
        end
        chk("t3_count", a_count, 16);
        chk("t3_ovf", a_ovf, 1);
        drive(1'b0, 5'd0, 32'd0, 5'd0, 1'b0, 1'b1);
        tick();
        chk("t3_rearm", {a_count, a_ovf, a_valid}, 0);
        for (int i = 0; i < 16; i++) write_tick(5'(1 + i), 32'h100 + 32'(i), 1'b0);
        chk("t3b_full_count", a_count, 16);
        write_tick(5'd1, 32'h110, 1'b1);
        chk("t3b_count", a_count, 16);
        chk("t3b_ovf", a_ovf, 0);
        chk("t3b_head", {a_addr, a_data}, {5'd2, 32'h101});
        drive(1'b0, 5'd0, 32'd0, 5'd0, 1'b0, 1'b1);
        tick();
        chk("t3b_rearm", {a_count, a_ovf}, 0);

        // T4: trigger on r30 then 6 further writes
        write_tick(5'd30, 32'h1, 1'b0);
        chk("t4_trig_count", a_count, 1);
        chk("t4_trig_frozen", a_frozen, 0);
        chk("t4_b_frozen", b_frozen, 1);
        chk("t4_b_count", b_count, 1);
        for (int i = 1; i <= 6; i++) begin
            write_tick(5'(i), 32'hA0 + 32'(i), 1'b0);
            if (i == 3) chk("t4_post3_frozen", a_frozen, 0);
            if (i == 4) chk("t4_post4_frozen", a_frozen, 1);
        end
        chk("t4_count", a_count, 5);
        chk("t4_b_count_after", b_count, 1);
        chk("t4_head", {a_addr, a_data}, {5'd30, 32'h1});
        dbg_raddr = 5'd6;
        #1;
        chk("t4_shadow_r6", a_rdata, 32'hA6);

        // T5: rearm while frozen with a simultaneous pop and write
        drive(1'b1, 5'd7, 32'h77, 5'd0, 1'b1, 1'b1);
        tick();
        chk("t5_state", {a_count, a_ovf, a_frozen, a_valid}, 0);
        chk("t5_b_state", {b_count, b_frozen}, 0);
        write_tick(5'd30, 32'h2, 1'b0);
        chk("t5_retrig", {a_count, a_frozen}, {5'd1, 1'b0});
        write_tick(5'd1, 32'hB1, 1'b0);
        write_tick(5'd30, 32'hB2, 1'b0);
        write_tick(5'd2, 32'hB3, 1'b0);
        chk("t5_no_restart", a_frozen, 0);
        write_tick(5'd3, 32'hB4, 1'b0);
        chk("t5_frozen", {a_count, a_frozen}, {5'd5, 1'b1});

        // T6: reset mid-drain, then stamp wrap on the 4-bit instance
        reset = 1'b0;
        tick();
        chk("t6_reset_discard", {a_count, a_valid}, 0);
        dbg_raddr = 5'd3;
        #1;
        chk("t6_shadow_clear", a_rdata, 0);
        tick();
        reset = 1'b1;
        repeat (17) tick();
        write_tick(5'd9, 32'h99, 1'b0);
        chk("t6_a_stamp", a_stamp, 16'd17);
        chk("t6_b_stamp", b_stamp, 4'd1);
        chk("t6_b_entry", {b_valid, b_addr, b_data}, {1'b1, 5'd9, 32'h99});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
